// File: rtl/acq_trigger_ctrl_pkg.sv
// Shared encodings for the acquisition trigger controller.
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        DONE     = 3'd4
    } acq_state_e;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/acq_trigger_ctrl_trig_detect.sv
// Edge detector: remembers the previous accepted sample of the capture and
// flags a level crossing on the current one.
module trig_detect
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  accept_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic                  edge_i,
    output logic                  hit_o
);

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  rise, fall;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear_i) begin
            prev_valid_d = 1'b0;
        end else if (accept_i) begin
            prev_d       = sample_i;
            prev_valid_d = 1'b1;
        end
    end

    // Strict on prev, inclusive on the current sample: equal-to-level fires once.
    assign rise  = (prev_q < level_i) && (sample_i >= level_i);
    assign fall  = (prev_q > level_i) && (sample_i <= level_i);
    assign hit_o = accept_i && prev_valid_q && ((edge_i == EDGE_RISING) ? rise : fall);

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: pre-trigger fill, arm, trigger, post-trigger collect,
// writing every in-capture sample to the capture buffer.
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_edge,
    input  logic [ADDR_WIDTH:0]   pretrigger,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_rdy,
    output logic                  adc_ack,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    acq_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH:0]   pre_q, pre_d;
    logic [ADDR_WIDTH:0]   num_q, num_d;
    logic [DATA_WIDTH-1:0] lvl_q, lvl_d;
    logic                  edge_q, edge_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  force_pend_q, force_pend_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  in_capture, accept, cfg_ok, det_clear, det_hit;
    logic [ADDR_WIDTH:0]   post_len;

    // Every sample is acknowledged so the ADC side never sees an overrun.
    assign adc_ack    = adc_rdy;
    assign in_capture = (state_q == PRE_FILL) || (state_q == ARMED) || (state_q == POST);
    assign accept     = adc_rdy && in_capture;
    assign cfg_ok     = (num_samples != '0) && (num_samples <= DEPTH) && (pretrigger < num_samples);
    assign post_len   = num_q - pre_q - ONE;

    trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig_detect (
        .clk_i    (clk_i),
        .reset    (reset),
        .sample_i (adc_data),
        .accept_i (accept),
        .clear_i  (det_clear),
        .level_i  (lvl_q),
        .edge_i   (edge_q),
        .hit_o    (det_hit)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            pre_q        <= '0;
            num_q        <= '0;
            lvl_q        <= '0;
            edge_q       <= EDGE_RISING;
            ptr_q        <= '0;
            force_pend_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            trig_addr_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            pre_q        <= pre_d;
            num_q        <= num_d;
            lvl_q        <= lvl_d;
            edge_q       <= edge_d;
            ptr_q        <= ptr_d;
            force_pend_q <= force_pend_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            trig_addr_q  <= trig_addr_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        pre_d        = pre_q;
        num_d        = num_q;
        lvl_d        = lvl_q;
        edge_d       = edge_q;
        ptr_d        = ptr_q;
        force_pend_d = force_pend_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        trig_addr_d  = trig_addr_q;
        cfg_err_d    = cfg_err_q;
        det_clear    = 1'b0;

        // A sample accepted on a stop edge is dropped, not written.
        if (accept && !stop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = adc_data;
            ptr_d     = ptr_q + 1'b1;
        end

        if (stop) begin
            state_d      = IDLE;
            force_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_err_d    = 1'b0;
                            pre_d        = pretrigger;
                            num_d        = num_samples;
                            lvl_d        = trig_level;
                            edge_d       = trig_edge;
                            cnt_d        = '0;
                            ptr_d        = '0;
                            force_pend_d = 1'b0;
                            det_clear    = 1'b1;
                            state_d      = (pretrigger == '0) ? ARMED : PRE_FILL;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                PRE_FILL: begin
                    if (accept) begin
                        cnt_d = cnt_q + ONE;
                        if (cnt_q + ONE == pre_q) state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (accept && (det_hit || force_trig || force_pend_q)) begin
                        trig_addr_d  = ptr_q;
                        force_pend_d = 1'b0;
                        rem_d        = post_len;
                        state_d      = (post_len == '0) ? DONE : POST;
                    end else if (force_trig) begin
                        force_pend_d = 1'b1;
                    end
                end
                POST: begin
                    if (accept) begin
                        rem_d = rem_q - ONE;
                        if (rem_q == ONE) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_addr = trig_addr_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = in_capture;
    assign done      = (state_q == DONE);

endmodule
